stq_alloc_ctl: RTL and testbench
================================

Name: stq_alloc_ctl

Overview:
- Pointer and control stage directly upstream of the 64-entry store-queue address buffer array.
- Allocates up to two store-queue entries per cycle in program order and drives the one-hot write enables for both write ports.
- Marks entries as passed (retired) when the ROB commits stores, and drives free enables when the L1 drains the oldest entry or an exception flushes unretired entries.
- Exports occupancy, full and empty status to the rename/dispatch stall logic.

Parameters:
- BUF_COUNT, 64, number of store-queue entries; must be a power of two.
- PTR_W, 6, log2(BUF_COUNT); pointers carry one extra wrap bit (PTR_W+1 bits).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- stallA  input  1  pipeline stall; suppresses allocation only.
- excpt  input  1  exception flush pulse.
- alloc0_req  input  1  request one entry, port 0.
- alloc1_req  input  1  request a second entry, port 1; valid only with alloc0_req.
- alloc_gnt  output  1  requested allocation accepted this cycle.
- wrt0_en  output  BUF_COUNT  one-hot write enable, port 0.
- wrt1_en  output  BUF_COUNT  one-hot write enable, port 1.
- wrt0_idx  output  PTR_W  entry index given to port 0.
- wrt1_idx  output  PTR_W  entry index given to port 1.
- retire_cnt  input  2  stores committed this cycle (0..2).
- passe_en  output  BUF_COUNT  mark entries as passed (retired).
- drain_req  input  1  L1 has written the oldest passed entry.
- free_en  output  BUF_COUNT  free entries (drain or flush).
- count  output  PTR_W+1  occupied entries, 0..BUF_COUNT.
- full  output  1  count==BUF_COUNT.
- empty  output  1  count==0.

Behaviour:
- State
  - Pointers `head` (oldest occupied), `ret` (oldest unretired) and `tail` (next free), each PTR_W+1 bits.
  - Ordering invariant: head<=ret<=tail in modulo-2*BUF_COUNT distance.
  - FSM with two states: RUN and FLUSH.
- Reset: head=ret=tail=0, state=RUN. All enables are 0, alloc_gnt=0, count=0, full=0, empty=1. Assertion of rst mid-operation aborts immediately; nothing pending survives.
- Derived values
  - used = tail-head, count = used, full/empty derived from used; all combinational from registers.
  - space = BUF_COUNT-used. Same-cycle frees are not credited toward space.
- Allocation
  - need = alloc0_req + (alloc0_req & alloc1_req). alloc1_req without alloc0_req is ignored.
  - alloc_gnt = (need!=0) & (space>=need) & ~stallA & ~excpt & (state==RUN).
  - Grant is all-or-nothing: a two-entry request with space==1 gets no grant.
  - On grant: wrt0_en has bit tail[PTR_W-1:0] set. If need==2, wrt1_en has bit (tail+1)[PTR_W-1:0] set, wrapping 63 to 0. tail += need.
  - wrt*_idx always show tail and tail+1. Enables are combinational, zero latency, same cycle as grant.
- Retire
  - eff = min(retire_cnt, tail-ret).
  - passe_en has bits ret .. ret+eff-1 set, with wrap. ret += eff.
  - Retire is honoured in an excpt cycle.
- Drain
  - If drain_req and head!=ret: free_en bit head is set and head += 1.
  - drain_req with no passed entry is ignored.
- Flush
  - On excpt: free_en also has every bit in [ret+eff, tail) set, and tail <= ret+eff.
  - The free_en mask is the OR of the drain bit and the flush bits.
  - The same cycle's allocation is suppressed. State goes to FLUSH for exactly one cycle; alloc_gnt=0 in FLUSH; then RUN.
  - excpt during FLUSH re-enters FLUSH, and its flush range is empty.
- Stall: stallA blocks only allocation; retire, drain and flush proceed.
- Simultaneous events: drain, retire, allocation and flush in one cycle update independent pointers and must not corrupt each other. A one-hot bit never appears in both wrt*_en and free_en in the same cycle.

Test Plan:
- Reset, then 32 cycles of two-entry allocation -> wrt0_en/wrt1_en walk bits 0..63 in pairs; full=1 and count=64 after cycle 32; next request gives alloc_gnt=0.
- tail=63, head=10, two-entry request -> wrt0_en bit 63, wrt1_en bit 0, tail wrap bit toggles, count=55.
- 5 allocated, retire_cnt=2 then 2 then 2 -> passe_en bits {0,1}, {2,3}, then only {4}; ret=5; three drain_req pulses -> free_en bits 0, 1, 2, head=3.
- 8 allocated, 3 retired; excpt with retire_cnt=1 -> passe_en bit 3; free_en bits 4..7; tail=4; next cycle alloc_gnt=0 (FLUSH); following cycle grant resumes at index 4.
- space=1, alloc0+alloc1 requested while drain_req frees one -> alloc_gnt=0 that cycle; granted on the next cycle.
- rst asserted asynchronously mid-burst with count=40 -> all outputs at reset values before the next clk edge; empty=1.

Source files
------------

// File: rtl/stq_alloc_if.sv
// Allocation, retire, drain and status signals between dispatch and the
// store-queue allocation controller.
interface stq_alloc_if #(
    parameter int BUF_COUNT = 64,
    parameter int PTR_W     = 6
);
    logic                 stallA;
    logic                 excpt;
    logic                 alloc0_req;
    logic                 alloc1_req;
    logic                 alloc_gnt;
    logic [BUF_COUNT-1:0] wrt0_en;
    logic [BUF_COUNT-1:0] wrt1_en;
    logic [PTR_W-1:0]     wrt0_idx;
    logic [PTR_W-1:0]     wrt1_idx;
    logic [1:0]           retire_cnt;
    logic [BUF_COUNT-1:0] passe_en;
    logic                 drain_req;
    logic [BUF_COUNT-1:0] free_en;
    logic [PTR_W:0]       count;
    logic                 full;
    logic                 empty;

    modport master (
        output stallA, excpt, alloc0_req, alloc1_req, retire_cnt, drain_req,
        input  alloc_gnt, wrt0_en, wrt1_en, wrt0_idx, wrt1_idx, passe_en,
               free_en, count, full, empty
    );

    modport slave (
        input  stallA, excpt, alloc0_req, alloc1_req, retire_cnt, drain_req,
        output alloc_gnt, wrt0_en, wrt1_en, wrt0_idx, wrt1_idx, passe_en,
               free_en, count, full, empty
    );
endinterface

// File: rtl/stq_alloc_ctl.sv
// Store-queue pointer/control stage: in-order dual allocation, retire marking,
// drain of the oldest passed entry and exception flush of unretired entries.
module stq_alloc_ctl #(
    parameter int BUF_COUNT = 64,
    parameter int PTR_W     = 6
) (
    input  logic       clk,
    input  logic       rst,
    stq_alloc_if.slave bus
);
    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

    state_e               state_q, state_d;
    logic [PTR_W:0]       head_q, head_d;
    logic [PTR_W:0]       ret_q, ret_d;
    logic [PTR_W:0]       tail_q, tail_d;

    logic [PTR_W:0]       used, space, unret, fl_base, fl_len;
    logic [1:0]           need, eff;
    logic                 gnt, drain_ok;
    logic [PTR_W-1:0]     idx0, idx1, pidx, off;
    logic [BUF_COUNT-1:0] wen0, wen1, pmask, fmask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            head_q  <= '0;
            ret_q   <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            ret_q   <= ret_d;
            tail_q  <= tail_d;
        end
    end

    always_comb begin
        used     = tail_q - head_q;
        space    = (PTR_W+1)'(BUF_COUNT) - used;
        unret    = tail_q - ret_q;
        need     = {1'b0, bus.alloc0_req} + {1'b0, bus.alloc0_req & bus.alloc1_req};
        eff      = ((PTR_W+1)'(bus.retire_cnt) <= unret) ? bus.retire_cnt : unret[1:0];
        gnt      = ~rst & (need != 2'd0) & (space >= (PTR_W+1)'(need)) &
                   ~bus.stallA & ~bus.excpt & (state_q == RUN);
        drain_ok = ~rst & bus.drain_req & (head_q != ret_q);

        idx0 = tail_q[PTR_W-1:0];
        idx1 = idx0 + PTR_W'(1);
        wen0 = gnt ? (BUF_COUNT'(1) << idx0) : '0;
        wen1 = (gnt && need == 2'd2) ? (BUF_COUNT'(1) << idx1) : '0;

        pmask = '0;
        pidx  = '0;
        for (int k = 0; k < 3; k++) begin
            if (~rst && 2'(k) < eff) begin
                pidx        = ret_q[PTR_W-1:0] + PTR_W'(k);
                pmask[pidx] = 1'b1;
            end
        end

        // Flush window is everything allocated beyond what retires this cycle.
        fl_base = ret_q + (PTR_W+1)'(eff);
        fl_len  = tail_q - fl_base;
        fmask   = '0;
        off     = '0;
        if (drain_ok)
            fmask[head_q[PTR_W-1:0]] = 1'b1;
        if (~rst && bus.excpt) begin
            for (int i = 0; i < BUF_COUNT; i++) begin
                off = PTR_W'(i) - fl_base[PTR_W-1:0];
                if ({1'b0, off} < fl_len)
                    fmask[i] = 1'b1;
            end
        end

        head_d  = head_q + (PTR_W+1)'(drain_ok);
        ret_d   = fl_base;
        tail_d  = tail_q;
        state_d = RUN;
        if (bus.excpt) begin
            tail_d  = fl_base;
            state_d = FLUSH;
        end else if (gnt) begin
            tail_d = tail_q + (PTR_W+1)'(need);
        end
    end

    assign bus.alloc_gnt = gnt;
    assign bus.wrt0_en   = wen0;
    assign bus.wrt1_en   = wen1;
    assign bus.wrt0_idx  = idx0;
    assign bus.wrt1_idx  = idx1;
    assign bus.passe_en  = pmask;
    assign bus.free_en   = fmask;
    assign bus.count     = used;
    assign bus.full      = (used == (PTR_W+1)'(BUF_COUNT));
    assign bus.empty     = (used == '0);
endmodule

// File: tb/tb_stq_alloc_ctl.sv
// Bench for stq_alloc_ctl: directed scenarios plus a randomized run against
// an integer-sequence reference model.
module tb_stq_alloc_ctl;
    localparam int N  = 64;
    localparam int PW = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stq_alloc_if #(.BUF_COUNT(N), .PTR_W(PW)) ifc ();
    stq_alloc_ctl #(.BUF_COUNT(N), .PTR_W(PW)) dut (.clk(clk), .rst(rst), .bus(ifc));

    int chk  = 0;
    int pass = 0;

    task automatic set_in(input logic a0, input logic a1, input logic st, input logic ex,
                          input logic [1:0] rc, input logic dr);
        ifc.alloc0_req = a0;
        ifc.alloc1_req = a1;
        ifc.stallA     = st;
        ifc.excpt      = ex;
        ifc.retire_cnt = rc;
        ifc.drain_req  = dr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic alloc_n(input int n);
        int left = n;
        while (left >= 2) begin
            set_in(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
            tick();
            left -= 2;
        end
        if (left == 1) begin
            set_in(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
            tick();
        end
        idle();
    endtask

    task automatic retire_n(input int n);
        int left = n;
        while (left > 0) begin
            set_in(1'b0, 1'b0, 1'b0, 1'b0, (left >= 2) ? 2'd2 : 2'd1, 1'b0);
            tick();
            left -= (left >= 2) ? 2 : 1;
        end
        idle();
    endtask

    task automatic drain_n(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
            tick();
        end
        idle();
    endtask

    task automatic test_reset();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1);
        rst = 1'b1;
        #2;
        chk++;
        if ({ifc.count, ifc.full, ifc.empty} !== {7'd0, 1'b0, 1'b1})
            $display("FAIL reset_status got count=%0d full=%b empty=%b want 0 0 1",
                     ifc.count, ifc.full, ifc.empty);
        else pass++;
        chk++;
        if ({ifc.alloc_gnt, ifc.wrt0_en, ifc.wrt1_en, ifc.passe_en, ifc.free_en} !== '0)
            $display("FAIL reset_enables got gnt=%b w0=%h w1=%h p=%h f=%h want all 0",
                     ifc.alloc_gnt, ifc.wrt0_en, ifc.wrt1_en, ifc.passe_en, ifc.free_en);
        else pass++;
        idle();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_fill();
        logic [N-1:0] e0, e1;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            set_in(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
            #1;
            e0 = 64'd1 << (2 * i);
            e1 = 64'd1 << (2 * i + 1);
            chk++;
            if ({ifc.alloc_gnt, ifc.wrt0_en, ifc.wrt1_en} !== {1'b1, e0, e1})
                $display("FAIL fill_pair%0d got gnt=%b w0=%h w1=%h want 1 %h %h",
                         i, ifc.alloc_gnt, ifc.wrt0_en, ifc.wrt1_en, e0, e1);
            else pass++;
            tick();
        end
        idle();
        #1;
        chk++;
        if ({ifc.count, ifc.full, ifc.empty} !== {7'd64, 1'b1, 1'b0})
            $display("FAIL fill_full got count=%0d full=%b empty=%b want 64 1 0",
                     ifc.count, ifc.full, ifc.empty);
        else pass++;
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        #1;
        chk++;
        if ({ifc.alloc_gnt, ifc.wrt0_en} !== '0)
            $display("FAIL fill_overflow got gnt=%b w0=%h want 0 0", ifc.alloc_gnt, ifc.wrt0_en);
        else pass++;
        tick();
        idle();
    endtask

    task automatic test_wrap();
        do_reset();
        alloc_n(63);
        retire_n(10);
        drain_n(10);
        #1;
        chk++;
        if (ifc.count !== 7'd53)
            $display("FAIL wrap_pre_count got %0d want 53", ifc.count);
        else pass++;
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        #1;
        chk++;
        if ({ifc.alloc_gnt, ifc.wrt0_en, ifc.wrt1_en, ifc.wrt0_idx, ifc.wrt1_idx} !==
            {1'b1, 64'h8000_0000_0000_0000, 64'h1, 6'd63, 6'd0})
            $display("FAIL wrap_enables got gnt=%b w0=%h w1=%h i0=%0d i1=%0d want 1 bit63 bit0 63 0",
                     ifc.alloc_gnt, ifc.wrt0_en, ifc.wrt1_en, ifc.wrt0_idx, ifc.wrt1_idx);
        else pass++;
        tick();
        idle();
        #1;
        chk++;
        if ({ifc.count, ifc.wrt0_idx} !== {7'd55, 6'd1})
            $display("FAIL wrap_post got count=%0d idx0=%0d want 55 1", ifc.count, ifc.wrt0_idx);
        else pass++;
    endtask

    task automatic test_retire_drain();
        logic [N-1:0] ep [3];
        ep[0] = 64'h3; ep[1] = 64'hC; ep[2] = 64'h10;
        do_reset();
        alloc_n(5);
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
            #1;
            chk++;
            if (ifc.passe_en !== ep[i])
                $display("FAIL retire_step%0d got %h want %h", i, ifc.passe_en, ep[i]);
            else pass++;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
            #1;
            chk++;
            if (ifc.free_en !== (64'd1 << i))
                $display("FAIL drain_step%0d got %h want %h", i, ifc.free_en, 64'd1 << i);
            else pass++;
            tick();
        end
        idle();
        #1;
        chk++;
        if (ifc.count !== 7'd2)
            $display("FAIL drain_count got %0d want 2", ifc.count);
        else pass++;
        // drain with nothing passed must be ignored
        do_reset();
        alloc_n(2);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        #1;
        chk++;
        if (ifc.free_en !== '0)
            $display("FAIL drain_unpassed got %h want 0", ifc.free_en);
        else pass++;
        tick();
        idle();
        #1;
        chk++;
        if (ifc.count !== 7'd2)
            $display("FAIL drain_unpassed_count got %0d want 2", ifc.count);
        else pass++;
    endtask

    task automatic test_flush();
        do_reset();
        alloc_n(8);
        retire_n(3);
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
        #1;
        chk++;
        if ({ifc.alloc_gnt, ifc.wrt0_en, ifc.passe_en, ifc.free_en} !==
            {1'b0, 64'h0, 64'h8, 64'hF0})
            $display("FAIL flush_cycle got gnt=%b w0=%h p=%h f=%h want 0 0 8 f0",
                     ifc.alloc_gnt, ifc.wrt0_en, ifc.passe_en, ifc.free_en);
        else pass++;
        tick();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        #1;
        chk++;
        if ({ifc.alloc_gnt, ifc.count} !== {1'b0, 7'd4})
            $display("FAIL flush_state got gnt=%b count=%0d want 0 4", ifc.alloc_gnt, ifc.count);
        else pass++;
        tick();
        #1;
        chk++;
        if ({ifc.alloc_gnt, ifc.wrt0_idx, ifc.wrt0_en} !== {1'b1, 6'd4, 64'h10})
            $display("FAIL flush_resume got gnt=%b idx=%0d w0=%h want 1 4 10",
                     ifc.alloc_gnt, ifc.wrt0_idx, ifc.wrt0_en);
        else pass++;
        tick();
        idle();
    endtask

    task automatic test_space_one();
        do_reset();
        alloc_n(63);
        retire_n(1);
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
        #1;
        chk++;
        if ({ifc.alloc_gnt, ifc.free_en} !== {1'b0, 64'h1})
            $display("FAIL space1_blocked got gnt=%b f=%h want 0 1", ifc.alloc_gnt, ifc.free_en);
        else pass++;
        tick();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        #1;
        chk++;
        if ({ifc.alloc_gnt, ifc.wrt0_en, ifc.wrt1_en} !== {1'b1, 64'h8000_0000_0000_0000, 64'h1})
            $display("FAIL space1_next got gnt=%b w0=%h w1=%h want 1 bit63 bit0",
                     ifc.alloc_gnt, ifc.wrt0_en, ifc.wrt1_en);
        else pass++;
        tick();
        idle();
        #1;
        chk++;
        if ({ifc.count, ifc.full} !== {7'd64, 1'b1})
            $display("FAIL space1_full got count=%0d full=%b want 64 1", ifc.count, ifc.full);
        else pass++;
    endtask

    task automatic test_stall();
        do_reset();
        alloc_n(4);
        retire_n(1);
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1);
        #1;
        chk++;
        if ({ifc.alloc_gnt, ifc.wrt0_en, ifc.passe_en, ifc.free_en} !== {1'b0, 64'h0, 64'h6, 64'h1})
            $display("FAIL stall_cycle got gnt=%b w0=%h p=%h f=%h want 0 0 6 1",
                     ifc.alloc_gnt, ifc.wrt0_en, ifc.passe_en, ifc.free_en);
        else pass++;
        tick();
        idle();
        #1;
        chk++;
        if (ifc.count !== 7'd3)
            $display("FAIL stall_count got %0d want 3", ifc.count);
        else pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        alloc_n(40);
        #1;
        chk++;
        if (ifc.count !== 7'd40)
            $display("FAIL areset_pre got %0d want 40", ifc.count);
        else pass++;
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk++;
        if ({ifc.count, ifc.full, ifc.empty, ifc.alloc_gnt, ifc.wrt0_en, ifc.wrt1_en} !==
            {7'd0, 1'b0, 1'b1, 1'b0, 64'h0, 64'h0})
            $display("FAIL areset_mid got count=%0d full=%b empty=%b gnt=%b w0=%h w1=%h want 0 0 1 0 0 0",
                     ifc.count, ifc.full, ifc.empty, ifc.alloc_gnt, ifc.wrt0_en, ifc.wrt1_en);
        else pass++;
        idle();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_random();
        int h, r, t, need, eff, used;
        bit fl, g, dok, a0, a1, st, ex, dr;
        int rc;
        logic [N-1:0] e0, e1, ep, ef;
        do_reset();
        h = 0; r = 0; t = 0; fl = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            a0 = ($urandom_range(0, 99) < (((cyc / 100) % 2 == 0) ? 85 : 30));
            a1 = ($urandom_range(0, 1) == 1);
            st = ($urandom_range(0, 9) == 0);
            ex = ($urandom_range(0, 29) == 0);
            rc = $urandom_range(0, 2);
            dr = ($urandom_range(0, 99) < (((cyc / 100) % 2 == 0) ? 30 : 80));
            set_in(a0, a1, st, ex, rc[1:0], dr);
            #1;
            used = t - h;
            need = a0 ? (a1 ? 2 : 1) : 0;
            g    = (need > 0) && (N - used >= need) && !st && !ex && !fl;
            e0   = g ? (64'd1 << (t % N)) : 64'd0;
            e1   = (g && need == 2) ? (64'd1 << ((t + 1) % N)) : 64'd0;
            eff  = (rc < t - r) ? rc : t - r;
            ep   = '0;
            for (int k = 0; k < eff; k++) ep[(r + k) % N] = 1'b1;
            dok  = dr && (h < r);
            ef   = '0;
            if (dok) ef[h % N] = 1'b1;
            if (ex) for (int s = r + eff; s < t; s++) ef[s % N] = 1'b1;

            chk++;
            if ({ifc.alloc_gnt, ifc.wrt0_en, ifc.wrt1_en} !== {g, e0, e1})
                $display("FAIL rnd_alloc c%0d got gnt=%b w0=%h w1=%h want %b %h %h",
                         cyc, ifc.alloc_gnt, ifc.wrt0_en, ifc.wrt1_en, g, e0, e1);
            else pass++;
            chk++;
            if ({ifc.wrt0_idx, ifc.wrt1_idx} !== {6'(t % N), 6'((t + 1) % N)})
                $display("FAIL rnd_idx c%0d got %0d %0d want %0d %0d",
                         cyc, ifc.wrt0_idx, ifc.wrt1_idx, t % N, (t + 1) % N);
            else pass++;
            chk++;
            if ({ifc.passe_en, ifc.free_en} !== {ep, ef})
                $display("FAIL rnd_masks c%0d got p=%h f=%h want %h %h",
                         cyc, ifc.passe_en, ifc.free_en, ep, ef);
            else pass++;
            chk++;
            if ({ifc.count, ifc.full, ifc.empty} !== {7'(used), used == N, used == 0})
                $display("FAIL rnd_status c%0d got count=%0d full=%b empty=%b want %0d %b %b",
                         cyc, ifc.count, ifc.full, ifc.empty, used, used == N, used == 0);
            else pass++;
            chk++;
            if (((ifc.wrt0_en | ifc.wrt1_en) & ifc.free_en) !== '0)
                $display("FAIL rnd_overlap c%0d got w=%h f=%h want disjoint",
                         cyc, ifc.wrt0_en | ifc.wrt1_en, ifc.free_en);
            else pass++;

            tick();
            h += dok ? 1 : 0;
            r += eff;
            if (ex) t = r;
            else if (g) t += need;
            fl = ex;
        end
        idle();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        #2;
        test_reset();
        test_fill();
        test_wrap();
        test_retire_drain();
        test_flush();
        test_space_one();
        test_stall();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule
